// File: rtl/rgmii_tx_pkg.sv
// Shared definitions for the RGMII transmit formatter: speed codes,
// formatter states and the default idle nibble.
package rgmii_tx_pkg;

    localparam logic [1:0] SPD_10       = 2'b00;
    localparam logic [1:0] SPD_100      = 2'b01;
    localparam logic [1:0] SPD_1000     = 2'b10;
    localparam logic [1:0] SPD_1000_ALT = 2'b11;

    localparam logic [3:0] IDLE_TXD_DEFAULT = 4'h0;

    // IDLE: nothing sent last edge; ONE: a full byte sent (gigabit);
    // LO: high nibble sent, ready for the next byte (10/100);
    // HI: low nibble sent, high nibble still pending (10/100).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONE  = 2'd1,
        LO   = 2'd2,
        HI   = 2'd3
    } tx_state_t;

    // Both 2'b10 and the reserved 2'b11 select byte-per-cycle operation.
    function automatic logic is_gig(input logic [1:0] spd);
        return (spd == SPD_1000) || (spd == SPD_1000_ALT);
    endfunction

endpackage

// File: rtl/rgmii_frame_cnt.sv
// Saturating frame counter; holds at all-ones instead of wrapping.
module rgmii_frame_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Increment unless already saturated.
    always_comb begin
        cnt_next = cnt_reg;
        if (inc && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/rgmii_tx_fmt.sv
// GMII byte stream to RGMII DDR-cell inputs. Gigabit sends a byte per
// cycle split across both edges; 10/100 sends the low nibble then the
// high nibble on consecutive cycles, each duplicated on both edges.
module rgmii_tx_fmt
    import rgmii_tx_pkg::*;
#(
    parameter logic [3:0] IDLE_TXD = IDLE_TXD_DEFAULT,
    parameter int         CNT_W    = 16
) (
    input  logic             C,
    input  logic             R,
    input  logic [1:0]       SPEED,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [7:0]       GMII_TXD,
    input  logic             GMII_TX_EN,
    input  logic             GMII_TX_ER,
    output logic [3:0]       TXD_D1,
    output logic [3:0]       TXD_D2,
    output logic             CTL_D1,
    output logic             CTL_D2,
    output logic             ERR,
    output logic [CNT_W-1:0] FRAME_CNT
);

    tx_state_t  state_reg, state_next;
    logic [1:0] spd_reg, spd_next;
    logic       frame_reg, frame_next;
    logic [3:0] hi_reg, hi_next;
    logic       hi_en_reg, hi_en_next;
    logic       hi_er_reg, hi_er_next;
    logic [3:0] txd_d1_reg, txd_d1_next;
    logic [3:0] txd_d2_reg, txd_d2_next;
    logic       ctl_d1_reg, ctl_d1_next;
    logic       ctl_d2_reg, ctl_d2_next;
    logic       err_reg, err_next;
    logic       accept;
    logic       overrun;
    logic       cnt_inc;

    // Ready depends only on state: no room while a high nibble is pending.
    assign IN_READY = (state_reg != HI);
    assign accept   = IN_VALID && IN_READY;
    assign overrun  = IN_VALID && !IN_READY;

    // Next-state, next-output and frame tracking.
    always_comb begin
        state_next  = IDLE;
        spd_next    = spd_reg;
        frame_next  = frame_reg;
        hi_next     = hi_reg;
        hi_en_next  = hi_en_reg;
        hi_er_next  = hi_er_reg;
        txd_d1_next = IDLE_TXD;
        txd_d2_next = IDLE_TXD;
        ctl_d1_next = 1'b0;
        ctl_d2_next = 1'b0;
        err_next    = err_reg || overrun;
        cnt_inc     = 1'b0;

        // Speed changes are only picked up between frames.
        if ((state_reg == IDLE) && !frame_reg) begin
            spd_next = SPEED;
        end

        if (state_reg == HI) begin
            // Emit the pending high nibble; a colliding byte poisons its
            // CTL_D2 so the receiver sees an error on this nibble.
            state_next  = LO;
            txd_d1_next = hi_reg;
            txd_d2_next = hi_reg;
            ctl_d1_next = hi_en_reg;
            ctl_d2_next = overrun ? ~hi_en_reg : (hi_en_reg ^ hi_er_reg);
        end else if (accept) begin
            ctl_d1_next = GMII_TX_EN;
            ctl_d2_next = GMII_TX_EN ^ GMII_TX_ER;
            if (is_gig(spd_reg)) begin
                state_next  = ONE;
                txd_d1_next = GMII_TXD[3:0];
                txd_d2_next = GMII_TXD[7:4];
            end else begin
                state_next  = HI;
                txd_d1_next = GMII_TXD[3:0];
                txd_d2_next = GMII_TXD[3:0];
                hi_next     = GMII_TXD[7:4];
                hi_en_next  = GMII_TX_EN;
                hi_er_next  = GMII_TX_ER;
            end
            if (GMII_TX_EN) begin
                frame_next = 1'b1;
            end else if (frame_reg) begin
                frame_next = 1'b0;
                cnt_inc    = 1'b1;
            end
        end
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_reg  <= IDLE;
            spd_reg    <= SPD_1000;
            frame_reg  <= 1'b0;
            hi_reg     <= 4'h0;
            hi_en_reg  <= 1'b0;
            hi_er_reg  <= 1'b0;
            txd_d1_reg <= IDLE_TXD;
            txd_d2_reg <= IDLE_TXD;
            ctl_d1_reg <= 1'b0;
            ctl_d2_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            spd_reg    <= spd_next;
            frame_reg  <= frame_next;
            hi_reg     <= hi_next;
            hi_en_reg  <= hi_en_next;
            hi_er_reg  <= hi_er_next;
            txd_d1_reg <= txd_d1_next;
            txd_d2_reg <= txd_d2_next;
            ctl_d1_reg <= ctl_d1_next;
            ctl_d2_reg <= ctl_d2_next;
            err_reg    <= err_next;
        end
    end

    assign TXD_D1 = txd_d1_reg;
    assign TXD_D2 = txd_d2_reg;
    assign CTL_D1 = ctl_d1_reg;
    assign CTL_D2 = ctl_d2_reg;
    assign ERR    = err_reg;

    rgmii_frame_cnt #(
        .CNT_W(CNT_W)
    ) u_frame_cnt (
        .clk(C),
        .rst(R),
        .inc(cnt_inc),
        .cnt(FRAME_CNT)
    );

endmodule

// File: tb/tb_rgmii_tx_fmt.sv
// Directed bench: each step drives one cycle of inputs and queues the
// hand-computed outputs expected after that edge; a monitor pops and
// compares on the following falling edge.
module tb_rgmii_tx_fmt;

    localparam logic [3:0] IDL = 4'hC;
    localparam int         CW  = 2;

    logic          C;
    logic          R;
    logic [1:0]    SPEED;
    logic          IN_VALID;
    logic          IN_READY;
    logic [7:0]    GMII_TXD;
    logic          GMII_TX_EN;
    logic          GMII_TX_ER;
    logic [3:0]    TXD_D1;
    logic [3:0]    TXD_D2;
    logic          CTL_D1;
    logic          CTL_D2;
    logic          ERR;
    logic [CW-1:0] FRAME_CNT;

    typedef struct {
        int         cyc;
        int         idx;
        logic [3:0] d1;
        logic [3:0] d2;
        logic       c1;
        logic       c2;
        logic       rdy;
        logic       err;
        logic [1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   step_idx = 0;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    rgmii_tx_fmt #(
        .IDLE_TXD(IDL),
        .CNT_W(CW)
    ) dut (
        .C(C),
        .R(R),
        .SPEED(SPEED),
        .IN_VALID(IN_VALID),
        .IN_READY(IN_READY),
        .GMII_TXD(GMII_TXD),
        .GMII_TX_EN(GMII_TX_EN),
        .GMII_TX_ER(GMII_TX_ER),
        .TXD_D1(TXD_D1),
        .TXD_D2(TXD_D2),
        .CTL_D1(CTL_D1),
        .CTL_D2(CTL_D2),
        .ERR(ERR),
        .FRAME_CNT(FRAME_CNT)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    always @(posedge C) cyc <= cyc + 1;

    // Monitor: compare the entry due for the edge just passed.
    always @(negedge C) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            chk_cnt++;
            if (TXD_D1 === e.d1 && TXD_D2 === e.d2 && CTL_D1 === e.c1 &&
                CTL_D2 === e.c2 && IN_READY === e.rdy && ERR === e.err &&
                FRAME_CNT === e.cnt) begin
                pass_cnt++;
                $display("step%0d ok: d1=%h d2=%h ctl=%b%b rdy=%b err=%b cnt=%0d",
                         e.idx, TXD_D1, TXD_D2, CTL_D1, CTL_D2, IN_READY, ERR, FRAME_CNT);
            end else begin
                $display("FAIL step%0d: got d1=%h d2=%h ctl=%b%b rdy=%b err=%b cnt=%0d, want d1=%h d2=%h ctl=%b%b rdy=%b err=%b cnt=%0d",
                         e.idx, TXD_D1, TXD_D2, CTL_D1, CTL_D2, IN_READY, ERR, FRAME_CNT,
                         e.d1, e.d2, e.c1, e.c2, e.rdy, e.err, e.cnt);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after its edge.
    task automatic step(input logic r, input logic [1:0] spd, input logic v,
                        input logic [7:0] d, input logic en, input logic er,
                        input logic [3:0] ed1, input logic [3:0] ed2,
                        input logic ec1, input logic ec2, input logic erdy,
                        input logic eerr, input logic [1:0] ecnt);
        exp_t e;
        @(negedge C);
        R          = r;
        SPEED      = spd;
        IN_VALID   = v;
        GMII_TXD   = d;
        GMII_TX_EN = en;
        GMII_TX_ER = er;
        e.cyc = cyc + 1;
        e.idx = step_idx;
        e.d1  = ed1;
        e.d2  = ed2;
        e.c1  = ec1;
        e.c2  = ec2;
        e.rdy = erdy;
        e.err = eerr;
        e.cnt = ecnt;
        exp_q.push_back(e);
        step_idx++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        R = 1'b1; SPEED = 2'b10; IN_VALID = 1'b0;
        GMII_TXD = 8'h00; GMII_TX_EN = 1'b0; GMII_TX_ER = 1'b0;
        //   r  spd   v  data  en er   d1    d2    c1 c2 rdy err cnt
        // reset and first idle cycle
        step(1, 2'b10, 0, 8'h00, 0, 0, IDL,  IDL,  0, 0, 1, 0, 2'd0);
        step(0, 2'b10, 0, 8'h00, 0, 0, IDL,  IDL,  0, 0, 1, 0, 2'd0);
        // frame 1 at 1000M: preamble bytes, an errored byte, end byte
        step(0, 2'b10, 1, 8'h55, 1, 0, 4'h5, 4'h5, 1, 1, 1, 0, 2'd0);
        step(0, 2'b10, 1, 8'hD5, 1, 0, 4'h5, 4'hD, 1, 1, 1, 0, 2'd0);
        step(0, 2'b10, 1, 8'hAB, 1, 1, 4'hB, 4'hA, 1, 0, 1, 0, 2'd0);
        step(0, 2'b10, 1, 8'h00, 0, 0, 4'h0, 4'h0, 0, 0, 1, 0, 2'd1);
        step(0, 2'b10, 0, 8'h00, 0, 0, IDL,  IDL,  0, 0, 1, 0, 2'd1);
        // frame 2: a valid gap inside the frame keeps it open
        step(0, 2'b10, 1, 8'h3E, 1, 0, 4'hE, 4'h3, 1, 1, 1, 0, 2'd1);
        step(0, 2'b10, 0, 8'h00, 0, 0, IDL,  IDL,  0, 0, 1, 0, 2'd1);
        step(0, 2'b10, 1, 8'h00, 0, 0, 4'h0, 4'h0, 0, 0, 1, 0, 2'd2);
        step(0, 2'b10, 0, 8'h00, 0, 0, IDL,  IDL,  0, 0, 1, 0, 2'd2);
        // frame 3: speed request moves to 100M mid-frame, still gigabit
        step(0, 2'b10, 1, 8'h12, 1, 0, 4'h2, 4'h1, 1, 1, 1, 0, 2'd2);
        step(0, 2'b01, 0, 8'h00, 0, 0, IDL,  IDL,  0, 0, 1, 0, 2'd2);
        step(0, 2'b01, 1, 8'h34, 1, 0, 4'h4, 4'h3, 1, 1, 1, 0, 2'd2);
        step(0, 2'b01, 1, 8'h00, 0, 0, 4'h0, 4'h0, 0, 0, 1, 0, 2'd3);
        step(0, 2'b01, 0, 8'h00, 0, 0, IDL,  IDL,  0, 0, 1, 0, 2'd3);
        step(0, 2'b01, 0, 8'h00, 0, 0, IDL,  IDL,  0, 0, 1, 0, 2'd3);
        // frame 4 at 100M: nibble split; count saturates at 3
        step(0, 2'b01, 1, 8'hA7, 1, 0, 4'h7, 4'h7, 1, 1, 0, 0, 2'd3);
        step(0, 2'b01, 0, 8'h00, 0, 0, 4'hA, 4'hA, 1, 1, 1, 0, 2'd3);
        step(0, 2'b01, 1, 8'h00, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 2'd3);
        step(0, 2'b00, 0, 8'h00, 0, 0, 4'h0, 4'h0, 0, 0, 1, 0, 2'd3);
        step(0, 2'b00, 0, 8'h00, 0, 0, IDL,  IDL,  0, 0, 1, 0, 2'd3);
        step(0, 2'b00, 0, 8'h00, 0, 0, IDL,  IDL,  0, 0, 1, 0, 2'd3);
        // 10M overrun: second byte dropped, high nibble CTL_D2 poisoned
        step(0, 2'b00, 1, 8'h11, 1, 0, 4'h1, 4'h1, 1, 1, 0, 0, 2'd3);
        step(0, 2'b00, 1, 8'h22, 1, 0, 4'h1, 4'h1, 1, 0, 1, 1, 2'd3);
        step(0, 2'b00, 0, 8'h00, 0, 0, IDL,  IDL,  0, 0, 1, 1, 2'd3);
        // reset while a high nibble is pending
        step(0, 2'b00, 1, 8'h5A, 1, 0, 4'hA, 4'hA, 1, 1, 0, 1, 2'd3);
        step(1, 2'b10, 0, 8'h00, 0, 0, IDL,  IDL,  0, 0, 1, 0, 2'd0);
        step(0, 2'b10, 0, 8'h00, 0, 0, IDL,  IDL,  0, 0, 1, 0, 2'd0);
        // back to gigabit after reset
        step(0, 2'b10, 1, 8'h96, 1, 0, 4'h6, 4'h9, 1, 1, 1, 0, 2'd0);
        step(0, 2'b10, 1, 8'h00, 0, 0, 4'h0, 4'h0, 0, 0, 1, 0, 2'd1);
        step(0, 2'b10, 0, 8'h00, 0, 0, IDL,  IDL,  0, 0, 1, 0, 2'd1);

        repeat (3) @(negedge C);
        #1;
        if (exp_q.size() != 0) begin
            chk_cnt++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
